// File: rtl/sram_arbiter.sv
// Single-port 256K-word x16 SRAM controller. It arbitrates a display read port and
// a capture write port. Define SRAM_ARB_STARVE_GUARD_EN to enable the write starvation guard.
module sram_arbiter #(
    parameter int WR_STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        rd_req,
    input  logic [17:0] rd_addr,
    output logic        rd_ack,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        wr_req,
    input  logic [17:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic        busy,
    output logic [17:0] SRAM0_A,
    inout  wire  [15:0] SRAM0_D,
    output logic        SRAM0_nOE,
    output logic        SRAM0_nWE,
    output logic        SRAM0_nCS,
    output logic [2:0]  dbg_state
);

    // Handshake: a requester holds req high with stable address/data until it sees the
    // one-cycle ack. The request is captured on the edge that starts the ack cycle, and a
    // request still high in the cycle after the ack counts as a new request.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        WR3  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ncs_q, ncs_d;
    logic        noe_q, noe_d;
    logic        nwe_q, nwe_d;
    logic        d_oe_q, d_oe_d;
    logic        rd_ack_q, rd_ack_d;
    logic        wr_ack_q, wr_ack_d;
    logic        rd_valid_q, rd_valid_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        busy_q, busy_d;

    logic        arb_point;
    logic        starve_trip;
    logic        grant_rd;
    logic        grant_wr;

    if (WR_STARVE_LIMIT < 1 || WR_STARVE_LIMIT > 15) begin : g_bad_starve_limit
    end

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIMIT = 4'(WR_STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    assign starve_trip = (starve_q == STARVE_LIMIT);

    // Counts reads granted past a waiting write; any gap in wr_req restarts the count.
    always_comb begin
        starve_d = starve_q;
        if (arb_point) begin
            if (!wr_req || grant_wr) begin
                starve_d = 4'd0;
            end else if (grant_rd && starve_q != STARVE_LIMIT) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_trip = 1'b0;
`endif

    assign arb_point = (state_q == IDLE) || (state_q == RD2) || (state_q == WR3);
    assign grant_wr  = arb_point && wr_req && (!rd_req || starve_trip);
    assign grant_rd  = arb_point && rd_req && !grant_wr;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            RD1:     state_d = RD2;
            WR1:     state_d = WR2;
            WR2:     state_d = WR3;
            default: begin
                if (grant_rd) begin
                    state_d = RD1;
                    addr_d  = rd_addr;
                end else if (grant_wr) begin
                    state_d = WR1;
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        // Pin controls are decoded from the next state so every SRAM pin comes from a flop.
        ncs_d      = (state_d == IDLE);
        noe_d      = !((state_d == RD1) || (state_d == RD2));
        nwe_d      = (state_d != WR2);
        d_oe_d     = (state_d == WR1) || (state_d == WR2) || (state_d == WR3);
        busy_d     = (state_d != IDLE);
        rd_ack_d   = grant_rd;
        wr_ack_d   = grant_wr;
        rd_valid_d = (state_q == RD2);
        rd_data_d  = (state_q == RD2) ? SRAM0_D : rd_data_q;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            addr_q     <= 18'd0;
            wdata_q    <= 16'd0;
            ncs_q      <= 1'b1;
            noe_q      <= 1'b1;
            nwe_q      <= 1'b1;
            d_oe_q     <= 1'b0;
            rd_ack_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 16'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ncs_q      <= ncs_d;
            noe_q      <= noe_d;
            nwe_q      <= nwe_d;
            d_oe_q     <= d_oe_d;
            rd_ack_q   <= rd_ack_d;
            wr_ack_q   <= wr_ack_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
        end
    end

    assign SRAM0_A   = addr_q;
    assign SRAM0_D   = d_oe_q ? wdata_q : 16'hzzzz;
    assign SRAM0_nCS = ncs_q;
    assign SRAM0_nOE = noe_q;
    assign SRAM0_nWE = nwe_q;
    assign rd_ack    = rd_ack_q;
    assign wr_ack    = wr_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
